mem_arbiter: RTL

- Shares the single-port data/program memory (16-bit words, async read, sync write) between two requesters.
- Port A is the CPU data port. Port B is the debug/program loader.
- Uses a registered req/gnt handshake with round-robin tie-breaking and a burst limit so neither requester starves the other.
- Sits between the requesters and the memory's addr/wdata/we/out pins.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU data port (A)
// and the debug/program loader (B) with round-robin ties and a burst limit.
module mem_arbiter #(
  parameter int WIDTH     = 16,
  parameter int ADD_SIZE  = 10,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_a,
  input  logic                we_a,
  input  logic [ADD_SIZE-1:0] addr_a,
  input  logic [WIDTH-1:0]    wdata_a,
  output logic                gnt_a,
  output logic [WIDTH-1:0]    rdata_a,
  input  logic                req_b,
  input  logic                we_b,
  input  logic [ADD_SIZE-1:0] addr_b,
  input  logic [WIDTH-1:0]    wdata_b,
  output logic                gnt_b,
  output logic [WIDTH-1:0]    rdata_b,
  output logic [ADD_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                mem_we,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic                busy
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_TOP = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_b;

  // The owner hands over directly when it releases or exhausts its burst while the other waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      burst_cnt <= '0;
      last_b    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_a && (!req_b || last_b)) begin
            state     <= OWN_A;
            gnt_a     <= 1'b1;
            burst_cnt <= '0;
            last_b    <= 1'b0;
          end else if (req_b) begin
            state     <= OWN_B;
            gnt_b     <= 1'b1;
            burst_cnt <= '0;
            last_b    <= 1'b1;
          end
        end
        OWN_A: begin
          if (req_b && (!req_a || burst_cnt == BURST_TOP)) begin
            state     <= OWN_B;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b1;
            burst_cnt <= '0;
            last_b    <= 1'b1;
          end else if (!req_a) begin
            state <= IDLE;
            gnt_a <= 1'b0;
          end else if (burst_cnt != BURST_TOP) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        OWN_B: begin
          if (req_a && (!req_b || burst_cnt == BURST_TOP)) begin
            state     <= OWN_A;
            gnt_b     <= 1'b0;
            gnt_a     <= 1'b1;
            burst_cnt <= '0;
            last_b    <= 1'b0;
          end else if (!req_b) begin
            state <= IDLE;
            gnt_b <= 1'b0;
          end else if (burst_cnt != BURST_TOP) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
        end
      endcase
    end
  end

  // Writes are gated by the live request so the trailing grant cycle after a release stays harmless.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (gnt_a) begin
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
      mem_we    = we_a & req_a;
    end else if (gnt_b) begin
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
      mem_we    = we_b & req_b;
    end
  end

  assign rdata_a = gnt_a ? mem_rdata : '0;
  assign rdata_b = gnt_b ? mem_rdata : '0;
  assign busy    = gnt_a | gnt_b;

endmodule
